// File: rtl/fft_sample_buffer_if.sv
// Sample-stream handshake and presented-frame bundle between the FFT feeder and its neighbours.
// The master side produces samples and consumes frames; the slave side is the buffer itself.
interface fft_sample_buffer_if #(
    parameter int WIDTH = 17
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_sample;
    logic                    in_ready;
    logic signed [WIDTH-1:0] sample1;
    logic signed [WIDTH-1:0] sample2;
    logic signed [WIDTH-1:0] sample3;
    logic signed [WIDTH-1:0] sample4;
    logic signed [WIDTH-1:0] sample5;
    logic signed [WIDTH-1:0] sample6;
    logic signed [WIDTH-1:0] sample7;
    logic signed [WIDTH-1:0] sample8;
    logic                    start;
    logic                    busy;

    modport master (
        output in_valid, in_sample,
        input  in_ready, sample1, sample2, sample3, sample4,
               sample5, sample6, sample7, sample8, start, busy
    );

    modport slave (
        input  in_valid, in_sample,
        output in_ready, sample1, sample2, sample3, sample4,
               sample5, sample6, sample7, sample8, start, busy
    );
endinterface

// File: rtl/fft_sample_buffer.sv
// Ping-pong frame assembler for the 8-point FFT: fills one bank serially while the other
// bank's frame is presented in parallel and frozen for HOLD_CYCLES after its start pulse.
module fft_sample_buffer #(
    parameter int WIDTH       = 17,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    fft_sample_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_PRESENT
    } bank_state_e;

    typedef enum logic {
        PRES_IDLE,
        PRES_HOLD
    } pres_state_e;

    typedef logic signed [WIDTH-1:0] word_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic        wptr_q, wptr_d;
    logic [2:0]  idx_q, idx_d;
    pres_state_e pres_q, pres_d;
    logic        pbank_q, pbank_d;
    logic [7:0]  hold_q, hold_d;
    logic        start_q, start_d;
    word_t       out_q [8];
    word_t       out_d [8];
    word_t       mem_q [2][8];

    logic in_ready;
    logic accept;
    logic load;
    logic load_bank;

    assign in_ready = (bank_q[wptr_q] == BANK_EMPTY) || (bank_q[wptr_q] == BANK_FILLING);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        for (int b = 0; b < 2; b++) bank_d[b] = bank_q[b];
        for (int k = 0; k < 8; k++) out_d[k] = out_q[k];
        wptr_d    = wptr_q;
        idx_d     = idx_q;
        pres_d    = pres_q;
        pbank_d   = pbank_q;
        hold_d    = hold_q;
        start_d   = 1'b0;
        load      = 1'b0;
        load_bank = 1'b0;

        if (accept) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                bank_d[wptr_q] = BANK_FULL;
                wptr_d         = ~wptr_q;
            end else begin
                bank_d[wptr_q] = BANK_FILLING;
            end
        end

        // The writer only touches an EMPTY/FILLING bank, so it never collides with the presenter's bank.
        case (pres_q)
            PRES_IDLE: begin
                if (bank_q[~wptr_q] == BANK_FULL) begin
                    load      = 1'b1;
                    load_bank = ~wptr_q;
                end else if (bank_q[wptr_q] == BANK_FULL) begin
                    load      = 1'b1;
                    load_bank = wptr_q;
                end
                if (load) begin
                    bank_d[load_bank] = BANK_PRESENT;
                    pbank_d           = load_bank;
                    hold_d            = HOLD_INIT;
                    start_d           = 1'b1;
                    pres_d            = PRES_HOLD;
                    for (int k = 0; k < 8; k++) out_d[k] = mem_q[load_bank][k];
                end
            end
            PRES_HOLD: begin
                hold_d = hold_q - 8'd1;
                if (hold_q == 8'd1) begin
                    bank_d[pbank_q] = BANK_EMPTY;
                    pres_d          = PRES_IDLE;
                end
            end
            default: pres_d = PRES_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) bank_q[b] <= BANK_EMPTY;
            for (int k = 0; k < 8; k++) out_q[k] <= '0;
            wptr_q  <= 1'b0;
            idx_q   <= 3'd0;
            pres_q  <= PRES_IDLE;
            pbank_q <= 1'b0;
            hold_q  <= 8'd0;
            start_q <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) bank_q[b] <= bank_d[b];
            for (int k = 0; k < 8; k++) out_q[k] <= out_d[k];
            wptr_q  <= wptr_d;
            idx_q   <= idx_d;
            pres_q  <= pres_d;
            pbank_q <= pbank_d;
            hold_q  <= hold_d;
            start_q <= start_d;
        end
    end

    // Sample storage needs no reset: bank state alone decides what is ever presented.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wptr_q][idx_q] <= bus.in_sample;
    end

    assign bus.in_ready = in_ready;
    assign bus.start    = start_q;
    assign bus.busy     = (pres_q == PRES_HOLD);
    assign bus.sample1  = out_q[0];
    assign bus.sample2  = out_q[1];
    assign bus.sample3  = out_q[2];
    assign bus.sample4  = out_q[3];
    assign bus.sample5  = out_q[4];
    assign bus.sample6  = out_q[5];
    assign bus.sample7  = out_q[6];
    assign bus.sample8  = out_q[7];

endmodule
